controlador_acesso_memoria: RTL
===============================

Name: controlador_acesso_memoria

Overview:
Initiator side of the data-memory interface. It accepts byte, halfword and word load/store requests from the CPU datapath on byte addresses and converts them into word-indexed accesses on the data memory port (clock, address, write-enable, write-data, combinational read-data). Sub-word stores use a read-modify-write sequence. It sits between the execute/MEM stage and memoria_de_dados.

Parameters:
MEM_SIZE, 150, number of 32-bit words in the attached data memory; word indices >= MEM_SIZE are out of range.
ADDR_WIDTH, 32, width of the CPU byte address and of the memory word-index port.

Ports:
clock  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
req  input  1  CPU request strobe; sampled only in OCIOSO
escrita  input  1  1 = store, 0 = load
tamanho  input  2  00 byte, 01 halfword, 10 word, 11 invalid
sem_sinal  input  1  load only: 1 = zero-extend, 0 = sign-extend
endereco_cpu  input  ADDR_WIDTH  byte address
dado_cpu  input  32  store data, right-aligned
dado_lido_cpu  output  32  load result, extended to 32 bits
pronto  output  1  one-cycle completion pulse
ocupado  output  1  high whenever state != OCIOSO
erro_alinhamento  output  1  valid with pronto
erro_faixa  output  1  valid with pronto
mem_endereco  output  ADDR_WIDTH  word index = byte address >> 2
mem_write  output  1  memory write enable
mem_dado_escrito  output  32  memory write data
mem_dado_lido  input  32  memory read data, combinational from mem_endereco

Behaviour:
- Reset: state OCIOSO. All outputs 0: pronto, ocupado, erros, dado_lido_cpu, mem_write, mem_endereco, mem_dado_escrito.
- States: OCIOSO, LER, ESCREVER, CONCLUIDO.
- Accept: in OCIOSO with req=1, latch escrita, tamanho, sem_sinal, endereco_cpu and dado_cpu. A req while ocupado is ignored; it is neither queued nor acknowledged.
- Error check at accept:
  - Alignment error: tamanho=11; halfword with addr[0]=1; word with addr[1:0]!=0.
  - Range error: (addr>>2) >= MEM_SIZE.
  - Any error: go to CONCLUIDO with no memory access. Alignment error takes priority when both apply. dado_lido_cpu is 0.
- Load: OCIOSO -> LER -> CONCLUIDO.
  - In LER, mem_endereco holds the word index.
  - At the end of LER, extract the lane selected by addr[1:0] (little-endian: lane 0 = bits 7:0), extend it, and register it into dado_lido_cpu.
  - pronto is asserted 2 cycles after the accept edge.
- Word store: OCIOSO -> ESCREVER -> CONCLUIDO. mem_write=1 for exactly one cycle with mem_dado_escrito=dado_cpu.
- Byte/halfword store: OCIOSO -> LER -> ESCREVER -> CONCLUIDO.
  - In LER, register the old word merged with dado_cpu[7:0] or [15:0] into the addressed lane(s). Other lanes are preserved.
  - pronto is asserted 3 cycles after accept.
- CONCLUIDO: pronto=1 for one cycle, then OCIOSO.
  - dado_lido_cpu and the error flags hold until the next accept.
  - A new req is accepted in the OCIOSO cycle after pronto. Back-to-back throughput is therefore 1 op per 3 cycles (load, word store) or 4 cycles (sub-word store).
- mem_write = (state==ESCREVER) && !reset. Reset asserted during ESCREVER suppresses the write on that edge.
- mem_endereco and mem_dado_escrito are registered and stable for the whole access.
- Reset in any state returns to OCIOSO on the next edge. No pronto is issued for the aborted op.
- The store path never drives mem_write in LER or CONCLUIDO.

Decomposition:
- Package pkg_acesso_memoria:
  - state enum: OCIOSO, LER, ESCREVER, CONCLUIDO;
  - tamanho codes TAM_BYTE=00, TAM_MEIA=01, TAM_PALAVRA=10;
  - lane-select helper constants.
- Sub-module alinhador_dados (combinational):
  - load lane extraction + sign/zero extension;
  - store lane merge (old word, new data, addr[1:0], tamanho → merged word).
- The FSM, latches and error check stay in controlador_acesso_memoria.

Test Plan:
- Word store then load: store 0xDEADBEEF at byte 0x10, then load word at 0x10.
  - mem_write pulses once with mem_endereco=4.
  - Load pronto 2 cycles after accept with dado_lido_cpu=0xDEADBEEF.
- Byte store read-modify-write: memory word 4 = 0x11223344; store byte 0xAA at 0x12.
  - Word becomes 0x11AA3344.
  - pronto 3 cycles after accept; mem_write high exactly 1 cycle.
- Sign/zero extension: word 4 = 0x80FF7F01.
  - Signed load byte 0x12 → 0xFFFFFFFF.
  - Unsigned load byte 0x12 → 0x000000FF.
  - Signed load half 0x12 → 0xFFFF80FF.
  - Signed load byte 0x10 → 0x00000001.
- Errors:
  - Word load at 0x13 → pronto next cycle, erro_alinhamento=1, mem_write never asserted.
  - Word store at byte 600 (index 150) → erro_faixa=1, no write.
  - tamanho=11 → erro_alinhamento=1.
- Reset mid-operation: assert reset during ESCREVER of a word store to 0x20.
  - Memory word 8 is unchanged; no pronto.
  - All outputs are 0 the cycle after reset.
  - Next load completes normally.
- Busy handshake: pulse a second req while ocupado=1.
  - It is ignored: exactly one pronto, one memory access, data from the first request only.

Source files
------------

// File: rtl/controlador_acesso_memoria_pkg.sv
// Shared types and constants for the CPU-side data-memory access controller.
// Holds the FSM encoding, access-size codes and byte-lane identifiers.
package pkg_acesso_memoria;

  typedef enum logic [1:0] {
    OCIOSO    = 2'd0,
    LER       = 2'd1,
    ESCREVER  = 2'd2,
    CONCLUIDO = 2'd3
  } estado_t;

  localparam logic [1:0] TAM_BYTE     = 2'b00;
  localparam logic [1:0] TAM_MEIA     = 2'b01;
  localparam logic [1:0] TAM_PALAVRA  = 2'b10;
  localparam logic [1:0] TAM_INVALIDO = 2'b11;

  localparam logic [1:0] LANE_0 = 2'd0;
  localparam logic [1:0] LANE_1 = 2'd1;
  localparam logic [1:0] LANE_2 = 2'd2;
  localparam logic [1:0] LANE_3 = 2'd3;

  // Halfwords must sit on even addresses, words on multiples of four.
  function automatic logic desalinhado(input logic [1:0] tamanho, input logic [1:0] lane);
    case (tamanho)
      TAM_BYTE:     return 1'b0;
      TAM_MEIA:     return lane[0];
      TAM_PALAVRA:  return lane != LANE_0;
      TAM_INVALIDO: return 1'b1;
      default:      return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/controlador_acesso_memoria_alinhador.sv
// Combinational byte-lane steering: load extraction with sign/zero extension
// and store merge of new data into the previously read word.
module alinhador_dados
  import pkg_acesso_memoria::*;
(
  input  logic [31:0] palavra_lida,
  input  logic [31:0] dado_novo,
  input  logic [1:0]  lane,
  input  logic [1:0]  tamanho,
  input  logic        sem_sinal,
  output logic [31:0] dado_extraido,
  output logic [31:0] palavra_mesclada
);

  logic [31:0] deslocado;

  assign deslocado = palavra_lida >> {lane, 3'b000};

  always_comb begin
    dado_extraido = deslocado;
    case (tamanho)
      TAM_BYTE: dado_extraido = sem_sinal ? {24'b0, deslocado[7:0]}
                                          : {{24{deslocado[7]}}, deslocado[7:0]};
      TAM_MEIA: dado_extraido = sem_sinal ? {16'b0, deslocado[15:0]}
                                          : {{16{deslocado[15]}}, deslocado[15:0]};
      default:  dado_extraido = palavra_lida;
    endcase
  end

  // Lanes outside the addressed byte/halfword keep their old contents.
  always_comb begin
    palavra_mesclada = palavra_lida;
    case (tamanho)
      TAM_BYTE: begin
        case (lane)
          LANE_0: palavra_mesclada[7:0]   = dado_novo[7:0];
          LANE_1: palavra_mesclada[15:8]  = dado_novo[7:0];
          LANE_2: palavra_mesclada[23:16] = dado_novo[7:0];
          LANE_3: palavra_mesclada[31:24] = dado_novo[7:0];
          default: palavra_mesclada = palavra_lida;
        endcase
      end
      TAM_MEIA: begin
        if (lane[1]) palavra_mesclada[31:16] = dado_novo[15:0];
        else         palavra_mesclada[15:0]  = dado_novo[15:0];
      end
      TAM_PALAVRA: palavra_mesclada = dado_novo;
      default:     palavra_mesclada = palavra_lida;
    endcase
  end

endmodule

// File: rtl/controlador_acesso_memoria.sv
// Initiator side of the data-memory port: turns byte-addressed CPU loads and
// stores into word-indexed accesses, using read-modify-write for sub-words.
module controlador_acesso_memoria
  import pkg_acesso_memoria::*;
#(
  parameter int MEM_SIZE   = 150,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req,
  input  logic                  escrita,
  input  logic [1:0]            tamanho,
  input  logic                  sem_sinal,
  input  logic [ADDR_WIDTH-1:0] endereco_cpu,
  input  logic [31:0]           dado_cpu,
  output logic [31:0]           dado_lido_cpu,
  output logic                  pronto,
  output logic                  ocupado,
  output logic                  erro_alinhamento,
  output logic                  erro_faixa,
  output logic [ADDR_WIDTH-1:0] mem_endereco,
  output logic                  mem_write,
  output logic [31:0]           mem_dado_escrito,
  input  logic [31:0]           mem_dado_lido
);

  estado_t     estado;
  logic        escrita_r;
  logic [1:0]  tamanho_r;
  logic        sem_sinal_r;
  logic [1:0]  lane_r;
  logic [31:0] dado_r;
  logic [31:0] dado_extraido;
  logic [31:0] palavra_mesclada;
  logic        erro_al_in;
  logic        erro_fx_in;

  alinhador_dados u_alinhador (
    .palavra_lida     (mem_dado_lido),
    .dado_novo        (dado_r),
    .lane             (lane_r),
    .tamanho          (tamanho_r),
    .sem_sinal        (sem_sinal_r),
    .dado_extraido    (dado_extraido),
    .palavra_mesclada (palavra_mesclada)
  );

  assign erro_al_in = desalinhado(tamanho, endereco_cpu[1:0]);
  assign erro_fx_in = (endereco_cpu >> 2) >= ADDR_WIDTH'(MEM_SIZE);

  // Gating with reset keeps an aborted store from landing in memory.
  assign mem_write = (estado == ESCREVER) && !reset;

  always_ff @(posedge clock) begin
    if (reset) begin
      estado           <= OCIOSO;
      pronto           <= 1'b0;
      ocupado          <= 1'b0;
      erro_alinhamento <= 1'b0;
      erro_faixa       <= 1'b0;
      dado_lido_cpu    <= '0;
      mem_endereco     <= '0;
      mem_dado_escrito <= '0;
      escrita_r        <= 1'b0;
      tamanho_r        <= TAM_BYTE;
      sem_sinal_r      <= 1'b0;
      lane_r           <= LANE_0;
      dado_r           <= '0;
    end else begin
      pronto <= 1'b0;
      case (estado)
        OCIOSO: begin
          if (req) begin
            escrita_r        <= escrita;
            tamanho_r        <= tamanho;
            sem_sinal_r      <= sem_sinal;
            lane_r           <= endereco_cpu[1:0];
            dado_r           <= dado_cpu;
            dado_lido_cpu    <= '0;
            erro_alinhamento <= erro_al_in;
            erro_faixa       <= erro_fx_in && !erro_al_in;
            mem_endereco     <= endereco_cpu >> 2;
            mem_dado_escrito <= dado_cpu;
            ocupado          <= 1'b1;
            if (erro_al_in || erro_fx_in) begin
              estado <= CONCLUIDO;
              pronto <= 1'b1;
            end else if (escrita && tamanho == TAM_PALAVRA) begin
              estado <= ESCREVER;
            end else begin
              estado <= LER;
            end
          end
        end
        LER: begin
          if (escrita_r) begin
            mem_dado_escrito <= palavra_mesclada;
            estado           <= ESCREVER;
          end else begin
            dado_lido_cpu <= dado_extraido;
            estado        <= CONCLUIDO;
            pronto        <= 1'b1;
          end
        end
        ESCREVER: begin
          estado <= CONCLUIDO;
          pronto <= 1'b1;
        end
        CONCLUIDO: begin
          estado  <= OCIOSO;
          ocupado <= 1'b0;
        end
        default: begin
          estado  <= OCIOSO;
          ocupado <= 1'b0;
        end
      endcase
    end
  end

endmodule
